// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared constants for the RV32I integer-computational decode stage:
//   - ALU operation encodings (identical to the integer ALU's op input)
//   - major opcodes handled by the decoder (OP, OP-IMM, LUI)
//   - funct7 patterns distinguishing the base and alternate operations
//   - micro-op payload width and the skid-buffer state type
//   - f3_to_op(): maps funct3 plus the "alternate" funct7 bit to an ALU op
// ---------------------------------------------------------------------------
package rv_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SLT  = 4'd1;
    localparam logic [3:0] ALU_SLTU = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SUB  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // op(4) + rs1(5) + rs2(5) + rd(5) + imm(32) + use_imm + wb_en + illegal
    localparam int UOP_W = 4 + 5 + 5 + 5 + 32 + 1 + 1 + 1;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } skid_state_t;

    function automatic logic [3:0] f3_to_op(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_skid_buf.sv
// ---------------------------------------------------------------------------
// rv_skid_buf
// Two-entry skid buffer (main + skid register) with valid/ready handshake.
// in_ready is a register, so there is no combinational path from out_ready
// to in_ready. Strict FIFO order; flush empties both entries and drops any
// input handshaking in the same cycle.
// Ports:
//   clk, rst_n (async, active-low), flush (sync)
//   in_valid / in_ready / in_data    : upstream side
//   out_valid / out_ready / out_data : downstream side (out_data = main reg)
// ---------------------------------------------------------------------------
module rv_skid_buf
    import rv_pkg::*;
#(
    parameter int WIDTH = UOP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_t      state_reg;
    logic [WIDTH-1:0] main_reg;
    logic [WIDTH-1:0] skid_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;

    logic accept;
    logic take;

    assign accept = in_valid && in_ready_reg;
    assign take   = out_valid_reg && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_EMPTY;
            main_reg      <= '0;
            skid_reg      <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else if (flush) begin
            state_reg     <= S_EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_EMPTY: begin
                    if (accept) begin
                        main_reg      <= in_data;
                        state_reg     <= S_ONE;
                        out_valid_reg <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (accept && !take) begin
                        // Downstream stalled: park the new word behind main.
                        skid_reg     <= in_data;
                        state_reg    <= S_FULL;
                        in_ready_reg <= 1'b0;
                    end else if (take && !accept) begin
                        state_reg     <= S_EMPTY;
                        out_valid_reg <= 1'b0;
                    end else if (take && accept) begin
                        main_reg <= in_data;
                    end
                end
                S_FULL: begin
                    if (take) begin
                        main_reg     <= skid_reg;
                        state_reg    <= S_ONE;
                        in_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= S_EMPTY;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = main_reg;

endmodule

// File: rtl/rv_decode_i.sv
// ---------------------------------------------------------------------------
// rv_decode_i
// RV32I integer-computational decode stage (OP, OP-IMM, LUI). Decodes the
// incoming instruction combinationally and registers the resulting ALU
// micro-op in a two-entry skid buffer (rv_skid_buf).
// Optional feature macro: RV_DECODE_ILLEGAL_EN
//   defined   : illegal encodings flagged with illegal_o=1, wb_en_o=0,
//               other fields decoded best-effort
//   undefined : illegal_o tied 0, illegal encodings emitted as a NOP
//               (ADD, rs1=rs2=rd=0, imm=0, use_imm=1, wb_en=0)
// Ports:
//   clk, rst_n (async, active-low), flush (sync)
//   in_valid, in_ready, in_instr[31:0]          : instruction input
//   out_valid, out_ready                        : micro-op handshake
//   op_o, rs1_o, rs2_o, rd_o, imm_o, use_imm_o,
//   wb_en_o, illegal_o                          : registered micro-op
// ---------------------------------------------------------------------------
module rv_decode_i
    import rv_pkg::*;
#(
    parameter int INSTR_WIDTH = 4,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] op_o,
    output logic [4:0]             rs1_o,
    output logic [4:0]             rs2_o,
    output logic [4:0]             rd_o,
    output logic [DATA_WIDTH-1:0]  imm_o,
    output logic                   use_imm_o,
    output logic                   wb_en_o,
    output logic                   illegal_o
);

    localparam int PAY_W = INSTR_WIDTH + 15 + DATA_WIDTH + 3;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    // Raw decode, before the legality policy is applied.
    logic [3:0]  raw_op;
    logic [4:0]  raw_rs1;
    logic [4:0]  raw_rs2;
    logic [4:0]  raw_rd;
    logic [31:0] raw_imm;
    logic        raw_use_imm;
    logic        legal;

    always_comb begin
        raw_op      = ALU_ADD;
        raw_rs1     = in_instr[19:15];
        raw_rs2     = in_instr[24:20];
        raw_rd      = in_instr[11:7];
        raw_imm     = '0;
        raw_use_imm = 1'b0;
        legal       = 1'b0;
        // Opcode constants all end in 2'b11, so compressed encodings
        // (instr[1:0] != 11) fall through to the illegal default.
        case (opcode)
            OPC_OP: begin
                legal  = (funct7 == F7_ZERO) ||
                         ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                raw_op = f3_to_op(funct3, funct7 == F7_ALT);
            end
            OPC_OP_IMM: begin
                raw_use_imm = 1'b1;
                raw_rs2     = '0;
                raw_imm     = {{20{in_instr[31]}}, in_instr[31:20]};
                legal       = 1'b1;
                // ADDI never becomes SUB: the alternate bit is ignored here.
                raw_op      = f3_to_op(funct3, 1'b0);
                if (funct3 == 3'b001) begin
                    raw_imm = {27'd0, in_instr[24:20]};
                    legal   = (funct7 == F7_ZERO);
                end else if (funct3 == 3'b101) begin
                    raw_imm = {27'd0, in_instr[24:20]};
                    legal   = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    raw_op  = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                end
            end
            OPC_LUI: begin
                raw_op      = ALU_ADD;
                raw_rs1     = '0;
                raw_rs2     = '0;
                raw_imm     = {in_instr[31:12], 12'd0};
                raw_use_imm = 1'b1;
                legal       = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // Final micro-op after applying the illegal-encoding policy.
    logic [3:0]  dec_op;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic [31:0] dec_imm;
    logic        dec_use_imm;
    logic        dec_wb_en;
    logic        dec_illegal;

    always_comb begin
        dec_op      = raw_op;
        dec_rs1     = raw_rs1;
        dec_rs2     = raw_rs2;
        dec_rd      = raw_rd;
        dec_imm     = raw_imm;
        dec_use_imm = raw_use_imm;
        dec_wb_en   = legal && (raw_rd != 5'd0);
        dec_illegal = 1'b0;
`ifdef RV_DECODE_ILLEGAL_EN
        dec_illegal = !legal;
`else
        if (!legal) begin
            dec_op      = ALU_ADD;
            dec_rs1     = '0;
            dec_rs2     = '0;
            dec_rd      = '0;
            dec_imm     = '0;
            dec_use_imm = 1'b1;
            dec_wb_en   = 1'b0;
        end
`endif
    end

    logic [PAY_W-1:0] pay_in;
    logic [PAY_W-1:0] pay_out;

    // Immediate is sign-extended from its 32-bit form to DATA_WIDTH; the
    // zero-extended shift amounts have bit 31 clear so they stay positive.
    assign pay_in = {INSTR_WIDTH'(dec_op), dec_rs1, dec_rs2, dec_rd,
                     DATA_WIDTH'($signed(dec_imm)), dec_use_imm, dec_wb_en, dec_illegal};

    rv_skid_buf #(
        .WIDTH(PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pay_out)
    );

    assign {op_o, rs1_o, rs2_o, rd_o, imm_o, use_imm_o, wb_en_o, illegal_o} = pay_out;

endmodule

// File: tb/tb_rv_decode_i.sv
// ---------------------------------------------------------------------------
// tb_rv_decode_i
// Scoreboard bench for rv_decode_i: every accepted instruction pushes its
// expected micro-op (from an independent reference decoder) into a queue;
// every output handshake pops and compares. The queue depth also predicts
// in_ready/out_valid each cycle. Honours RV_DECODE_ILLEGAL_EN like the DUT.
// ---------------------------------------------------------------------------
module tb_rv_decode_i;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  op_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [4:0]  rd_o;
    logic [31:0] imm_o;
    logic        use_imm_o;
    logic        wb_en_o;
    logic        illegal_o;

    always #5 clk = ~clk;

    rv_decode_i #(
        .INSTR_WIDTH(4),
        .DATA_WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op_o      (op_o),
        .rs1_o     (rs1_o),
        .rs2_o     (rs2_o),
        .rd_o      (rd_o),
        .imm_o     (imm_o),
        .use_imm_o (use_imm_o),
        .wb_en_o   (wb_en_o),
        .illegal_o (illegal_o)
    );

    int total = 0;
    int bad   = 0;
    logic [53:0] exp_q[$];
    logic [53:0] got_uop;

    assign got_uop = {op_o, rs1_o, rs2_o, rd_o, imm_o, use_imm_o, wb_en_o, illegal_o};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference decoder: {op, rs1, rs2, rd, imm, use_imm, wb_en, illegal}
    function automatic logic [53:0] ref_dec(input logic [31:0] w);
        logic [3:0]  op;
        logic [4:0]  a, b, d;
        logic [31:0] im;
        logic        ui, ok;
        logic [2:0]  f3;
        logic [6:0]  f7;
        f3 = w[14:12];
        f7 = w[31:25];
        a = w[19:15]; b = w[24:20]; d = w[11:7];
        im = 32'd0; ui = 1'b0; ok = 1'b0; op = 4'd0;
        if (w[6:0] == 7'h33) begin
            ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            case (f3)
                3'd0: op = (f7 == 7'h20) ? 4'd8 : 4'd0;
                3'd1: op = 4'd6;
                3'd2: op = 4'd1;
                3'd3: op = 4'd2;
                3'd4: op = 4'd5;
                3'd5: op = (f7 == 7'h20) ? 4'd9 : 4'd7;
                3'd6: op = 4'd4;
                default: op = 4'd3;
            endcase
        end else if (w[6:0] == 7'h13) begin
            ui = 1'b1; b = 5'd0; ok = 1'b1;
            im = {{20{w[31]}}, w[31:20]};
            case (f3)
                3'd0: op = 4'd0;
                3'd1: begin op = 4'd6; im = {27'd0, w[24:20]}; ok = (f7 == 7'h00); end
                3'd2: op = 4'd1;
                3'd3: op = 4'd2;
                3'd4: op = 4'd5;
                3'd5: begin
                    op = (f7 == 7'h20) ? 4'd9 : 4'd7;
                    im = {27'd0, w[24:20]};
                    ok = (f7 == 7'h00) || (f7 == 7'h20);
                end
                3'd6: op = 4'd4;
                default: op = 4'd3;
            endcase
        end else if (w[6:0] == 7'h37) begin
            op = 4'd0; a = 5'd0; b = 5'd0; ui = 1'b1; ok = 1'b1;
            im = {w[31:12], 12'h000};
        end
`ifdef RV_DECODE_ILLEGAL_EN
        return {op, a, b, d, im, ui, ok && (d != 5'd0), !ok};
`else
        if (!ok) return {4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0};
        return {op, a, b, d, im, ui, (d != 5'd0), 1'b0};
`endif
    endfunction

    // One clock of stimulus: drive on the falling edge, check predicted
    // handshake state, score any output transfer, record any accept.
    task automatic cyc(input logic v, input logic [31:0] w, input logic ordy,
                       input logic fl, output logic acc);
        logic [53:0] e;
        @(negedge clk);
        in_valid  = v;
        in_instr  = w;
        out_ready = ordy;
        flush     = fl;
        #1;
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() < 2});
        chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
        acc = v && in_ready && !fl;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (out_valid && ordy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("uop", {10'd0, got_uop}, {10'd0, e});
                    $display("txn out: op=%0d rs1=%0d rs2=%0d rd=%0d imm=%h use_imm=%0b wb=%0b ill=%0b",
                             op_o, rs1_o, rs2_o, rd_o, imm_o, use_imm_o, wb_en_o, illegal_o);
                end
            end
            if (acc) exp_q.push_back(ref_dec(w));
        end
    endtask

    task automatic drain();
        logic acc;
        repeat (4) cyc(1'b0, 32'd0, 1'b1, 1'b0, acc);
        chk("drained", 64'(exp_q.size()), 64'd0);
    endtask

    logic [31:0] tbl[14];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic acc;
        int   idx;
        logic [3:0] pat;

        tbl = '{32'h402081B3,   // SUB x3,x1,x2
                32'h40735293,   // SRAI x5,x6,7
                32'hFFF00093,   // ADDI x1,x0,-1
                32'hABCDE3B7,   // LUI x7,0xABCDE
                32'h00208033,   // ADD x0,x1,x2
                32'h00000073,   // ECALL (illegal)
                32'h022081B3,   // OP funct7=0x01 (illegal)
                32'h00321213,   // SLLI x4,x4,3
                32'h0020B4B3,   // SLTU x9,x1,x2
                32'h00208032,   // bad low bits (illegal)
                32'h40321213,   // SLLI with funct7=0x20 (illegal)
                32'hFFB5C513,   // XORI x10,x11,-5
                32'h00E6D633,   // SRL x12,x13,x14
                32'h4020C1B3};  // XOR funct7=0x20 (illegal)

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_payload", {10'd0, got_uop}, 64'd0);
        rst_n = 1'b1;

        // Directed decodes, full throughput.
        for (int i = 0; i < 14; i++) cyc(1'b1, tbl[i], 1'b1, 1'b0, acc);
        drain();

        // Back-to-back stream of 8 with out_ready pattern 1,0,0,1.
        pat = 4'b1001;
        idx = 0;
        for (int c = 0; c < 60 && idx < 8; c++) begin
            cyc(1'b1, tbl[idx], pat[c % 4], 1'b0, acc);
            if (acc) idx++;
        end
        chk("stream_sent", 64'(idx), 64'd8);
        drain();

        // Flush while FULL with an input presented.
        cyc(1'b1, tbl[0], 1'b0, 1'b0, acc);
        cyc(1'b1, tbl[1], 1'b0, 1'b0, acc);
        cyc(1'b1, 32'h00100093, 1'b0, 1'b1, acc);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, acc);
        cyc(1'b1, tbl[3], 1'b1, 1'b0, acc);
        drain();

        // Random traffic with occasional flushes.
        for (int c = 0; c < 150; c++) begin
            logic fl;
            fl = ($urandom_range(0, 15) == 0);
            cyc($urandom_range(0, 3) != 0, tbl[$urandom_range(0, 13)],
                fl ? 1'b0 : ($urandom_range(0, 2) != 0), fl, acc);
        end
        drain();

        // Asynchronous reset mid-operation.
        cyc(1'b1, tbl[2], 1'b0, 1'b0, acc);
        cyc(1'b1, tbl[3], 1'b0, 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("arst_payload", {10'd0, got_uop}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, tbl[11], 1'b1, 1'b0, acc);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
